// File: rtl/limb_norm_pkg.sv
// Shared definitions for the limb carry normalizer.
//   num_limbs(n)    : limb count produced by an n-limb signed multiplier (2n+1)
//   carry_w(b, w)   : signed carry width for a b+1-bit limb split into w-bit digits
//   norm_state_t    : normalizer control states
package limb_norm_pkg;

  localparam int DEF_NUM_ELEMENTS = 17;
  localparam int DEF_BIT_LEN      = 17;
  localparam int DEF_WORD_LEN     = 16;

  function automatic int num_limbs(input int numElements);
    return 2 * numElements + 1;
  endfunction

  // A limb plus an incoming carry stays below 2^(bitLen+1) in magnitude, so the
  // arithmetic-shifted carry needs bitLen-wordLen+2 bits; one more gives margin.
  function automatic int carry_w(input int bitLen, input int wordLen);
    return bitLen - wordLen + 3;
  endfunction

  localparam int DEF_NUM_LIMBS = num_limbs(DEF_NUM_ELEMENTS);
  localparam int DEF_CARRY_W   = carry_w(DEF_BIT_LEN, DEF_WORD_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROP = 2'd1,
    DONE = 2'd2
  } norm_state_t;

endpackage

// File: rtl/limb_carry_cell.sv
// One combinational carry-resolution step.
//   limb_i  : signed redundant limb, BIT_LEN+1 bits
//   carry_i : signed carry arriving from the next-lower limb
//   digit_o : canonical unsigned WORD_LEN-bit digit
//   carry_o : signed carry to the next-higher limb (arithmetic shift, never truncated)
module limb_carry_cell
  import limb_norm_pkg::*;
#(
  parameter int  BIT_LEN  = DEF_BIT_LEN,
  parameter int  WORD_LEN = DEF_WORD_LEN,
  localparam int CARRY_W  = carry_w(BIT_LEN, WORD_LEN)
) (
  input  logic signed [BIT_LEN:0]   limb_i,
  input  logic signed [CARRY_W-1:0] carry_i,
  output logic        [WORD_LEN-1:0] digit_o,
  output logic signed [CARRY_W-1:0] carry_o
);

  logic signed [BIT_LEN+1:0] sum;

  // Both operands are sign-extended to BIT_LEN+2 bits so the sum cannot overflow;
  // the low bits become the digit and the arithmetic shift yields the signed carry.
  always_comb begin
    sum     = {limb_i[BIT_LEN], limb_i}
            + {{(BIT_LEN + 2 - CARRY_W){carry_i[CARRY_W-1]}}, carry_i};
    digit_o = sum[WORD_LEN-1:0];
    carry_o = CARRY_W'(sum >>> WORD_LEN);
  end

endmodule

// File: rtl/limb_carry_normalizer.sv
// Sequential carry propagation for the signed limb multiplier output.
// Accepts NUM_LIMBS signed redundant limbs, resolves LIMBS_PER_CYCLE of them per
// cycle through a chain of limb_carry_cell instances, and presents canonical
// WORD_LEN-bit digits plus the signed carry out of the top limb.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (accepted only in IDLE)
//   in_limbs              : redundant input limbs, index 0 least significant
//   out_valid / out_ready : result handshake (held stable until accepted)
//   out_digits            : canonical digits, index 0 least significant
//   out_carry             : signed carry out of the top limb
//   out_neg               : result is negative
//   out_err               : carry not in {0,-1}, result does not fit the digits
module limb_carry_normalizer
  import limb_norm_pkg::*;
#(
  parameter int  NUM_ELEMENTS    = DEF_NUM_ELEMENTS,
  parameter int  BIT_LEN         = DEF_BIT_LEN,
  parameter int  WORD_LEN        = DEF_WORD_LEN,
  parameter int  LIMBS_PER_CYCLE = 1,
  localparam int NUM_LIMBS       = num_limbs(NUM_ELEMENTS),
  localparam int CARRY_W         = carry_w(BIT_LEN, WORD_LEN)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BIT_LEN:0]    in_limbs [NUM_LIMBS],
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic        [WORD_LEN-1:0] out_digits [NUM_LIMBS],
  output logic signed [CARRY_W-1:0]  out_carry,
  output logic                       out_neg,
  output logic                       out_err
);

  localparam int IDX_W = $clog2(NUM_LIMBS + LIMBS_PER_CYCLE + 1);
  localparam int SEL_W = $clog2(NUM_LIMBS);

  norm_state_t               state_q, state_d;
  logic signed [BIT_LEN:0]   limbBuf_q [NUM_LIMBS];
  logic [WORD_LEN-1:0]       digits_q  [NUM_LIMBS];
  logic [IDX_W-1:0]          idx_q;
  logic signed [CARRY_W-1:0] carry_q;
  logic                      outValid_q;

  logic                      laneValid [LIMBS_PER_CYCLE];
  logic [SEL_W-1:0]          laneSel   [LIMBS_PER_CYCLE];
  logic [WORD_LEN-1:0]       laneDigit [LIMBS_PER_CYCLE];
  logic signed [CARRY_W-1:0] chunkCarry;
  logic                      lastChunk;

  // Carry chain for one chunk. Lanes past the top limb in the final partial
  // chunk pass their incoming carry straight through instead of feeding a zero
  // limb through a cell, which would re-shift (and corrupt) a negative carry.
  for (genvar k = 0; k < LIMBS_PER_CYCLE; k++) begin : g_lane
    logic [IDX_W-1:0]          laneIdx;
    logic signed [BIT_LEN:0]   limb;
    logic signed [CARRY_W-1:0] cin;
    logic signed [CARRY_W-1:0] cout;

    assign laneIdx      = idx_q + IDX_W'(k);
    assign laneValid[k] = (laneIdx < IDX_W'(NUM_LIMBS));
    assign laneSel[k]   = laneIdx[SEL_W-1:0];
    assign limb         = laneValid[k] ? limbBuf_q[laneSel[k]] : '0;

    if (k == 0) begin : g_head
      assign cin = carry_q;
    end else begin : g_link
      assign cin = laneValid[k-1] ? g_lane[k-1].cout : g_lane[k-1].cin;
    end

    limb_carry_cell #(
      .BIT_LEN (BIT_LEN),
      .WORD_LEN(WORD_LEN)
    ) u_cell (
      .limb_i (limb),
      .carry_i(cin),
      .digit_o(laneDigit[k]),
      .carry_o(cout)
    );
  end

  assign chunkCarry = laneValid[LIMBS_PER_CYCLE-1] ? g_lane[LIMBS_PER_CYCLE-1].cout
                                                   : g_lane[LIMBS_PER_CYCLE-1].cin;
  assign lastChunk  = (int'(idx_q) + LIMBS_PER_CYCLE) >= NUM_LIMBS;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs. DONE spends its first cycle raising
  // out_valid, so the result is only offered once it has settled in registers.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = outValid_q;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = PROP;
      end
      PROP: begin
        if (lastChunk) state_d = DONE;
      end
      DONE: begin
        if (outValid_q && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, chunked carry resolution and result hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      carry_q    <= '0;
      outValid_q <= 1'b0;
      for (int i = 0; i < NUM_LIMBS; i++) begin
        limbBuf_q[i] <= '0;
        digits_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            limbBuf_q <= in_limbs;
            idx_q     <= '0;
            carry_q   <= '0;
          end
        end
        PROP: begin
          idx_q   <= idx_q + IDX_W'(LIMBS_PER_CYCLE);
          carry_q <= chunkCarry;
          for (int k = 0; k < LIMBS_PER_CYCLE; k++) begin
            if (laneValid[k]) digits_q[laneSel[k]] <= laneDigit[k];
          end
        end
        DONE: begin
          if (!outValid_q) begin
            outValid_q <= 1'b1;
          end else if (out_ready) begin
            outValid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_digits = digits_q;
  assign out_carry  = carry_q;
  assign out_neg    = carry_q[CARRY_W-1];
  assign out_err    = (carry_q != '0) && (carry_q != '1);

endmodule

// File: tb/tb_limb_carry_normalizer.sv
// Self-checking bench for limb_carry_normalizer. Three instances (1, 4 and 35
// limbs per cycle) receive the same operands; expected results come from a
// table of hand-computed vectors and from a wide-integer reference sum.
module tb_limb_carry_normalizer;
  import limb_norm_pkg::*;

  localparam int NL   = 35;
  localparam int NDUT = 3;
  localparam int LAT_TAB [NDUT] = '{36, 10, 2};

  typedef struct packed {
    int                 ia;
    logic signed [17:0] va;
    int                 ib;
    logic signed [17:0] vb;
    logic [15:0]        fill;
    int                 ea;
    logic [15:0]        da;
    int                 eb;
    logic [15:0]        db;
    logic signed [3:0]  carry;
    logic               neg;
    logic               err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic inValid;
  logic outReady;
  logic signed [17:0] inLimbs [NL];

  logic              inReady  [NDUT];
  logic              outValid [NDUT];
  logic signed [3:0] outCarry [NDUT];
  logic              outNeg   [NDUT];
  logic              outErr   [NDUT];
  logic [15:0]       digA [NL];
  logic [15:0]       digB [NL];
  logic [15:0]       digC [NL];

  logic signed [17:0] stimLimbs [NL];
  logic [15:0]        expDigits [NL];
  logic signed [3:0]  expCarry;
  logic               expNeg;
  logic               expErr;
  int                 latency [NDUT];

  int checks = 0;
  int errors = 0;

  vec_t vecs [8];

  always #5 clk = ~clk;

  limb_carry_normalizer #(.LIMBS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[0]), .in_limbs(inLimbs),
    .out_valid(outValid[0]), .out_ready(outReady), .out_digits(digA),
    .out_carry(outCarry[0]), .out_neg(outNeg[0]), .out_err(outErr[0])
  );

  limb_carry_normalizer #(.LIMBS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[1]), .in_limbs(inLimbs),
    .out_valid(outValid[1]), .out_ready(outReady), .out_digits(digB),
    .out_carry(outCarry[1]), .out_neg(outNeg[1]), .out_err(outErr[1])
  );

  limb_carry_normalizer #(.LIMBS_PER_CYCLE(35)) u_dut35 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[2]), .in_limbs(inLimbs),
    .out_valid(outValid[2]), .out_ready(outReady), .out_digits(digC),
    .out_carry(outCarry[2]), .out_neg(outNeg[2]), .out_err(outErr[2])
  );

  // Digit lookup across the three instances.
  function automatic logic [15:0] getDigit(input int d, input int i);
    case (d)
      0:       return digA[i];
      1:       return digB[i];
      default: return digC[i];
    endcase
  endfunction

  // Single scalar comparison with failure report.
  task automatic compareValue(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Full result comparison for one instance against the expected arrays.
  task automatic checkOutput(input int d, input string tag);
    int bad;
    bad = -1;
    for (int i = 0; i < NL; i++) begin
      if (bad < 0 && getDigit(d, i) !== expDigits[i]) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("[TB] FAIL %s dut%0d digit[%0d]: got %04h, expected %04h",
               tag, d, bad, getDigit(d, bad), expDigits[bad]);
    end
    compareValue($sformatf("%s dut%0d latency", tag, d), longint'(latency[d]), longint'(LAT_TAB[d]));
    compareValue($sformatf("%s dut%0d out_carry", tag, d), longint'(outCarry[d]), longint'(expCarry));
    compareValue($sformatf("%s dut%0d out_neg", tag, d), longint'(outNeg[d]), longint'(expNeg));
    compareValue($sformatf("%s dut%0d out_err", tag, d), longint'(outErr[d]), longint'(expErr));
  endtask

  // Load a sparse table vector into the stimulus and expected arrays.
  task automatic loadVector(input vec_t v);
    for (int i = 0; i < NL; i++) begin
      stimLimbs[i] = '0;
      expDigits[i] = v.fill;
    end
    if (v.ia >= 0) stimLimbs[v.ia] = v.va;
    if (v.ib >= 0) stimLimbs[v.ib] = v.vb;
    if (v.ea >= 0) expDigits[v.ea] = v.da;
    if (v.eb >= 0) expDigits[v.eb] = v.db;
    expCarry = v.carry;
    expNeg   = v.neg;
    expErr   = v.err;
  endtask

  // Wide-integer reference: sum the limbs at their weights, then read digits
  // and the carry straight out of the two's-complement total.
  task automatic modelExpected();
    logic signed [599:0] total;
    logic signed [599:0] term;
    logic [39:0]         top;
    total = '0;
    for (int i = 0; i < NL; i++) begin
      term  = {{582{stimLimbs[i][17]}}, stimLimbs[i]};
      total = total + (term <<< (16 * i));
    end
    for (int i = 0; i < NL; i++) expDigits[i] = total[16*i +: 16];
    top      = total[599:560];
    expCarry = total[563:560];
    expNeg   = total[599];
    expErr   = !((top == 40'h0) || (top == 40'hFF_FFFF_FFFF));
  endtask

  // Accept one operand on all instances, wait for every result, check, release.
  task automatic applyStimulus(input string tag);
    bit allDone;
    for (int d = 0; d < NDUT; d++) begin
      compareValue($sformatf("%s dut%0d in_ready idle", tag, d), longint'(inReady[d]), 1);
      latency[d] = -1;
    end
    inLimbs = stimLimbs;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    for (int i = 0; i < NL; i++) inLimbs[i] = 18'($urandom);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      allDone = 1'b1;
      for (int d = 0; d < NDUT; d++) begin
        if (latency[d] < 0 && outValid[d]) latency[d] = c;
        if (latency[d] < 0) allDone = 1'b0;
      end
      if (allDone) break;
    end
    for (int d = 0; d < NDUT; d++) checkOutput(d, tag);
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      compareValue($sformatf("%s dut%0d out_valid after handshake", tag, d), longint'(outValid[d]), 0);
      compareValue($sformatf("%s dut%0d in_ready after handshake", tag, d), longint'(inReady[d]), 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{-1, 18'sh00000, -1, 18'sh00000, 16'h0000, -1, 16'h0000, -1, 16'h0000, 4'sh0, 1'b0, 1'b0};
    vecs[1] = '{0,  18'sh1FFFF, -1, 18'sh00000, 16'h0000, 0,  16'hFFFF, 1,  16'h0001, 4'sh0, 1'b0, 1'b0};
    vecs[2] = '{0,  18'sh3FFFF, -1, 18'sh00000, 16'hFFFF, -1, 16'h0000, -1, 16'h0000, 4'shF, 1'b1, 1'b0};
    vecs[3] = '{34, 18'sh10000, -1, 18'sh00000, 16'h0000, 34, 16'h0000, -1, 16'h0000, 4'sh1, 1'b0, 1'b1};
    vecs[4] = '{0,  18'sh10000, 1,  18'sh3FFFF, 16'h0000, -1, 16'h0000, -1, 16'h0000, 4'sh0, 1'b0, 1'b0};
    vecs[5] = '{0,  18'sh20000, -1, 18'sh00000, 16'hFFFF, 0,  16'h0000, 1,  16'hFFFE, 4'shF, 1'b1, 1'b0};
    vecs[6] = '{34, 18'sh2FFFF, -1, 18'sh00000, 16'h0000, 34, 16'hFFFF, -1, 16'h0000, 4'shE, 1'b1, 1'b1};
    vecs[7] = '{33, 18'sh1FFFF, 34, 18'sh1FFFF, 16'h0000, 33, 16'hFFFF, 34, 16'h0000, 4'sh2, 1'b0, 1'b1};

    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    for (int i = 0; i < NL; i++) inLimbs[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      int nz;
      nz = 0;
      for (int i = 0; i < NL; i++) if (getDigit(d, i) != 16'h0) nz++;
      compareValue($sformatf("reset dut%0d in_ready", d), longint'(inReady[d]), 1);
      compareValue($sformatf("reset dut%0d out_valid", d), longint'(outValid[d]), 0);
      compareValue($sformatf("reset dut%0d nonzero digits", d), longint'(nz), 0);
      compareValue($sformatf("reset dut%0d out_carry", d), longint'(outCarry[d]), 0);
      compareValue($sformatf("reset dut%0d out_neg", d), longint'(outNeg[d]), 0);
      compareValue($sformatf("reset dut%0d out_err", d), longint'(outErr[d]), 0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      loadVector(vecs[v]);
      applyStimulus($sformatf("vec%0d", v));
    end

    // Back-pressure: result held for 10 cycles while upstream keeps offering data.
    loadVector(vecs[1]);
    inLimbs = stimLimbs;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    begin
      int waited;
      waited = 0;
      while (!outValid[0] && waited < 60) begin
        @(posedge clk);
        #1;
        waited++;
      end
      compareValue("hold out_valid reached", longint'(outValid[0]), 1);
    end
    for (int c = 0; c < 10; c++) begin
      inValid = 1'b1;
      for (int i = 0; i < NL; i++) inLimbs[i] = 18'($urandom);
      @(posedge clk);
      #1;
      compareValue($sformatf("hold cycle%0d state", c),
                   longint'({outValid[0], inReady[0], digA[0], digA[1], outCarry[0]}),
                   longint'({1'b1, 1'b0, 16'hFFFF, 16'h0001, 4'sh0}));
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    outReady = 1'b0;
    compareValue("hold release out_valid", longint'(outValid[0]), 0);
    compareValue("hold release in_ready", longint'(inReady[0]), 1);
    @(posedge clk);
    #1;
    compareValue("hold nothing accepted", longint'({outValid[0], inReady[0]}), longint'(2'b01));

    // Reset in the middle of carry propagation.
    loadVector(vecs[2]);
    inLimbs = stimLimbs;
    inValid = 1'b1;
    @(posedge clk);
    #1;
    inValid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    compareValue("midprop busy", longint'({outValid[0], inReady[0]}), 0);
    compareValue("midprop digit0 written", longint'(digA[0]), longint'(16'hFFFF));
    rst = 1'b1;
    @(posedge clk);
    #1;
    compareValue("midprop reset in_ready", longint'(inReady[0]), 1);
    compareValue("midprop reset out_valid", longint'(outValid[0]), 0);
    compareValue("midprop reset digit0", longint'(digA[0]), 0);
    compareValue("midprop reset out_carry", longint'(outCarry[0]), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("after reset");

    // Random signed limbs against the wide-integer model.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < NL; i++) stimLimbs[i] = 18'($urandom);
      if (r == 0) for (int i = 0; i < NL; i++) stimLimbs[i] = 18'sh20000;
      if (r == 1) for (int i = 0; i < NL; i++) stimLimbs[i] = 18'sh1FFFF;
      modelExpected();
      applyStimulus($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
